packet_receiver: RTL

PACKET_RECEIVER -- requirements
Module: packet_receiver

---
 rtl/packet_receiver.sv | 114 +++++++++++
 1 files changed

// File: rtl/packet_receiver.sv
// UART packet receiver: parses SYNC/Dest/Src/Length headers and emits one
// registered stream beat per payload byte, aborting on length 0 or idle timeout.
package Structures;
    typedef struct packed {
        logic       Valid;
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic       SoP;
        logic       EoP;
        logic [7:0] Data;
    } UART_PACKET;
endpackage

module packet_receiver
    import Structures::*;
#(
    parameter logic [7:0]  SYNC_BYTE = 8'h55,
    parameter int unsigned TIMEOUT   = 50000
) (
    input  logic       ipClk,
    input  logic       ipReset,
    input  logic [7:0] ipRxData,
    input  logic       ipRxValid,
    output UART_PACKET opRxStream,
    output logic       opError
);
    localparam int GW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, GET_DEST, GET_SRC, GET_LENGTH, GET_DATA} state_t;

    state_t        r_state, w_state_next;
    logic [GW-1:0] r_gap;
    logic [7:0]    r_cnt, r_dest, r_src, r_len;
    logic          r_first;
    logic          w_timeout, w_beat, w_error;

    assign w_timeout = (r_state != IDLE) && (r_gap == GW'(TIMEOUT));

    // A strobe always wins over a coincident timeout.
    always_comb begin
        w_state_next = r_state;
        w_beat       = 1'b0;
        w_error      = 1'b0;
        if (ipRxValid) begin
            unique case (r_state)
                IDLE:       if (ipRxData == SYNC_BYTE) w_state_next = GET_DEST;
                GET_DEST:   w_state_next = GET_SRC;
                GET_SRC:    w_state_next = GET_LENGTH;
                GET_LENGTH: begin
                    if (ipRxData == 8'd0) begin
                        w_state_next = IDLE;
                        w_error      = 1'b1;
                    end else begin
                        w_state_next = GET_DATA;
                    end
                end
                GET_DATA: begin
                    w_beat = 1'b1;
                    if (r_cnt <= 8'd1) w_state_next = IDLE;
                end
                default:    w_state_next = IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_next = IDLE;
            w_error      = 1'b1;
        end
    end

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            r_state    <= IDLE;
            r_gap      <= '0;
            r_cnt      <= '0;
            r_dest     <= '0;
            r_src      <= '0;
            r_len      <= '0;
            r_first    <= 1'b0;
            opRxStream <= '0;
            opError    <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            opError          <= w_error;
            opRxStream.Valid <= w_beat;
            opRxStream.SoP   <= w_beat && r_first;
            opRxStream.EoP   <= w_beat && (r_cnt == 8'd1);

            if (ipRxValid || r_state == IDLE || w_timeout) r_gap <= '0;
            else                                           r_gap <= r_gap + GW'(1);

            if (ipRxValid) begin
                unique case (r_state)
                    GET_DEST:   r_dest <= ipRxData;
                    GET_SRC:    r_src  <= ipRxData;
                    GET_LENGTH: begin
                        r_len   <= ipRxData;
                        r_cnt   <= ipRxData;
                        r_first <= 1'b1;
                    end
                    GET_DATA: begin
                        // Saturating decrement: the counter never wraps below zero.
                        if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
                        r_first                <= 1'b0;
                        opRxStream.Data        <= ipRxData;
                        opRxStream.Source      <= r_src;
                        opRxStream.Destination <= r_dest;
                        opRxStream.Length      <= r_len;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
